gshare_pht: RTL and testbench
=============================

// Module: gshare_pht
// PURPOSE
//  Parametrised gshare direction predictor: pattern history table of saturating counters, global history register (GHR)
//  and an init sweep that replaces the fixed 256x2 write/read macro. Sits in the fetch stage: fetch sends a PC, the block
//  returns taken/not-taken one cycle later. The backend trains counters and repairs the GHR on mispredict.
// PARAMETERS
//  PC_WIDTH     32  fetch PC width
//  INDEX_WIDTH   8  PHT index bits; DEPTH = 1<<INDEX_WIDTH entries
//  GHR_WIDTH     8  global history bits; 1 <= GHR_WIDTH <= INDEX_WIDTH
//  CTR_WIDTH     2  saturating counter bits; MSB = predict taken
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            async active-low reset
//  pred_valid     in   1            prediction request
//  pred_pc        in   PC_WIDTH     PC to predict
//  pred_ready     out  1            request accepted when pred_valid & pred_ready
//  resp_valid     out  1            response valid, exactly one cycle after accept
//  resp_taken     out  1            resp_ctr[CTR_WIDTH-1]
//  resp_ctr       out  CTR_WIDTH    counter value read; backend returns it on update
//  resp_index     out  INDEX_WIDTH  PHT index used
//  resp_ghr       out  GHR_WIDTH    GHR value used to form the index (checkpoint)
//  upd_valid      in   1            train request (always accepted; dropped during INIT)
//  upd_index      in   INDEX_WIDTH  entry to train
//  upd_ctr        in   CTR_WIDTH    counter value returned at prediction time
//  upd_taken      in   1            resolved direction
//  upd_mispredict in   1            repair GHR from checkpoint
//  upd_ghr        in   GHR_WIDTH    checkpoint GHR of the branch
//  init_done      out  1            0 while sweeping, 1 in RUN
// BEHAVIOUR
//  - Reset (async, any time incl. mid-sweep/mid-response): state=INIT, sweep_ptr=0, ghr=0, resp_valid=0,
//    pred_ready=0, init_done=0, resp_* data=0. PHT contents are not reset; the sweep rewrites them.
//  - INIT: one write per cycle, PHT[sweep_ptr] <= WEAK_NT = 2^(CTR_WIDTH-1)-1 (2'b01); ptr wraps DEPTH-1 -> 0 and
//    moves to RUN. Exactly DEPTH cycles. pred_ready=0; upd_valid ignored (no write, no GHR change).
//  - RUN: pred_ready=1 every cycle (one prediction per cycle).
//  - Index = pred_pc[INDEX_WIDTH+1:2] ^ {0, ghr_eff}; ghr_eff = resp_valid ? {ghr[GHR_WIDTH-2:0], resp_taken} : ghr
//    (speculative history of the in-flight response forwarded to the next back-to-back request).
//  - Latency: accept in cycle N -> resp_valid=1 in N+1 with resp_index and resp_ghr=ghr_eff of cycle N.
//  - GHR update per edge, priority: upd_valid&upd_mispredict -> {upd_ghr[GHR_WIDTH-2:0], upd_taken};
//    else resp_valid -> {ghr[GHR_WIDTH-2:0], resp_taken}; else hold. Mispredict wins over a simultaneous resp shift.
//  - Training: upd_valid in cycle N writes PHT[upd_index] at edge ending N with
//    taken ? min(upd_ctr+1, 2^CTR_WIDTH-1) : max(upd_ctr-1, 0); saturating, no wrap. Written even if unchanged.
//  - Read/write collision: an update and a request to the same index in the same cycle -> response shows the
//    newly written value (write-first). Updates in the response cycle do not alter the held response.
//  - Only one write port: sweep and training never coexist (training dropped in INIT), so no arbitration.
// STRUCTURE
//  - gshare_pkg: CTR_WIDTH-typed ctr_t, WEAK_NT, CTR_MAX, state enum {INIT, RUN}, sat_inc/sat_dec functions.
//  - Sub-module gshare_pht_ram: DEPTH x CTR_WIDTH, 1W1R, synchronous read (dout registered), write-first
//    bypass on same-address collision. Top holds FSM, sweep counter, GHR, index hash and response registers.
// TESTING
//  - Reset release -> init_done=0, pred_ready=0 for 256 cycles, init_done=1 on cycle 256; upd_valid in INIT -> no effect.
//  - After init, ghr=0, pc=0x100 -> resp next cycle: index=0x40, ctr=2'b01, taken=0, resp_ghr=0; GHR becomes 0x00.
//  - Updates taken to index 0x40 with ctr 01, 10, 11 -> stored 10, 11, 11 (saturate); ctr 00 & not-taken -> 00.
//  - Same-cycle upd(index 0x40, ctr 01, taken) and pred pc=0x100 -> resp_ctr=2'b10, taken=1.
//  - Back-to-back preds with first resp taken=1: second index uses ghr_eff=0x01; simultaneous mispredict
//    upd_ghr=0x5A, taken=0 -> ghr=0xB4, resp shift ignored.
//  - rst_n pulsed low at sweep_ptr=100 or with resp_valid=1 -> outputs clear immediately; full 256-cycle sweep restarts.

Source files
------------

// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare direction predictor.
//   ctr_t     : default-width saturating counter type
//   WEAK_NT   : weakly-not-taken counter value written by the init sweep
//   CTR_MAX   : largest value of a default-width counter
//   state_t   : controller state (INIT sweep, RUN)
//   sat_inc / sat_dec : saturating step helpers, width-generic up to 16 bits
package gshare_pkg;

    localparam int PKG_CTR_WIDTH = 2;

    typedef logic [PKG_CTR_WIDTH-1:0] ctr_t;

    localparam ctr_t WEAK_NT = ctr_t'((1 << (PKG_CTR_WIDTH - 1)) - 1);
    localparam ctr_t CTR_MAX = ctr_t'((1 << PKG_CTR_WIDTH) - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counters of any width up to 16 bits are carried in a 16-bit container
    // so one helper serves every CTR_WIDTH instance.
    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic [15:0] max_value);
        return (value >= max_value) ? max_value : value + 16'd1;
    endfunction

    function automatic logic [15:0] sat_dec(input logic [15:0] value);
        return (value == 16'd0) ? 16'd0 : value - 16'd1;
    endfunction

endpackage

// File: rtl/gshare_pht_ram.sv
// Pattern history table storage: DEPTH x CTR_WIDTH, one write port, one
// read port with registered output.
//   clk, rst_n : clock, async active-low reset (clears only the read register)
//   we, waddr, wdata : write port
//   re, raddr        : read request; dout updates on the following edge
//   dout             : registered read data, held while re is low
// A write and read of the same address in one cycle returns the new data.
module gshare_pht_ram
    import gshare_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int CTR_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] waddr,
    input  logic [CTR_WIDTH-1:0]   wdata,
    input  logic                   re,
    input  logic [INDEX_WIDTH-1:0] raddr,
    output logic [CTR_WIDTH-1:0]   dout
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    logic [CTR_WIDTH-1:0] mem [DEPTH];

    // Array contents are deliberately not reset; the init sweep rewrites them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (re) begin
            dout <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/gshare_pht.sv
// Gshare branch direction predictor for the fetch stage.
//   clk, rst_n            : clock, async active-low reset
//   pred_valid/pred_pc    : prediction request; accepted when pred_ready
//   pred_ready            : high in RUN, one request per cycle
//   resp_valid            : pulses the cycle after an accept
//   resp_taken/resp_ctr   : predicted direction and raw counter
//   resp_index/resp_ghr   : PHT index and history checkpoint used
//   upd_*                 : training and history repair from the backend
//   init_done             : low while the PHT is swept to weakly-not-taken
module gshare_pht
    import gshare_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INDEX_WIDTH = 8,
    parameter int GHR_WIDTH   = 8,
    parameter int CTR_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pred_valid,
    input  logic [PC_WIDTH-1:0]    pred_pc,
    output logic                   pred_ready,
    output logic                   resp_valid,
    output logic                   resp_taken,
    output logic [CTR_WIDTH-1:0]   resp_ctr,
    output logic [INDEX_WIDTH-1:0] resp_index,
    output logic [GHR_WIDTH-1:0]   resp_ghr,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic [CTR_WIDTH-1:0]   upd_ctr,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict,
    input  logic [GHR_WIDTH-1:0]   upd_ghr,
    output logic                   init_done
);

    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_TOP  = CTR_WIDTH'((1 << CTR_WIDTH) - 1);

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   sweep_ptr;
    logic [GHR_WIDTH-1:0]     ghr;
    logic [GHR_WIDTH-1:0]     ghr_eff;
    logic [INDEX_WIDTH-1:0]   pred_index;
    logic                     accept;
    logic                     train;
    logic                     ram_we;
    logic [INDEX_WIDTH-1:0]   ram_waddr;
    logic [CTR_WIDTH-1:0]     ram_wdata;
    logic [CTR_WIDTH-1:0]     trained_ctr;
    logic                     unused_pc_bits;

    // Shift one outcome into a history value; works for GHR_WIDTH == 1 too.
    function automatic logic [GHR_WIDTH-1:0] push_hist(input logic [GHR_WIDTH-1:0] hist, input logic bit_in);
        return (hist << 1) | GHR_WIDTH'(bit_in);
    endfunction

    // Controller: INIT sweeps every entry once, then RUN forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && (&sweep_ptr)) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_ptr <= '0;
        end else if (state_q == INIT) begin
            sweep_ptr <= sweep_ptr + 1'b1;
        end
    end

    assign pred_ready = (state_q == RUN);
    assign init_done  = (state_q == RUN);
    assign accept     = pred_valid && pred_ready;
    assign train      = upd_valid && (state_q == RUN);

    // The response still in flight has not yet reached the GHR; forward its
    // outcome so a back-to-back request sees up-to-date history.
    assign ghr_eff    = resp_valid ? push_hist(ghr, resp_taken) : ghr;
    assign pred_index = pred_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_eff);

    assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_WIDTH+2], pred_pc[1:0]};

    assign trained_ctr = upd_taken
        ? CTR_WIDTH'(sat_inc(16'(upd_ctr), 16'(CTR_TOP)))
        : CTR_WIDTH'(sat_dec(16'(upd_ctr)));

    // Sweep and training share the single write port; training is dropped in INIT.
    assign ram_we    = (state_q == INIT) || train;
    assign ram_waddr = (state_q == INIT) ? sweep_ptr : upd_index;
    assign ram_wdata = (state_q == INIT) ? CTR_INIT : trained_ctr;

    gshare_pht_ram #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .CTR_WIDTH  (CTR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (accept),
        .raddr(pred_index),
        .dout (resp_ctr)
    );

    assign resp_taken = resp_ctr[CTR_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_index <= '0;
            resp_ghr   <= '0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_index <= pred_index;
                resp_ghr   <= ghr_eff;
            end
        end
    end

    // A mispredict repair overrides the speculative shift of a concurrent response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (train && upd_mispredict) begin
            ghr <= push_hist(upd_ghr, upd_taken);
        end else if (resp_valid) begin
            ghr <= push_hist(ghr, resp_taken);
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with default parameters (256 x 2-bit PHT, 8-bit GHR).
module tb_gshare_pht;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic        resp_valid;
    logic        resp_taken;
    logic [1:0]  resp_ctr;
    logic [7:0]  resp_index;
    logic [7:0]  resp_ghr;
    logic        upd_valid;
    logic [7:0]  upd_index;
    logic [1:0]  upd_ctr;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [7:0]  upd_ghr;
    logic        init_done;

    int          n_assert;
    int          n_fail;
    logic [7:0]  tb_ghr;

    gshare_pht dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_ready    (pred_ready),
        .resp_valid    (resp_valid),
        .resp_taken    (resp_taken),
        .resp_ctr      (resp_ctr),
        .resp_index    (resp_index),
        .resp_ghr      (resp_ghr),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_ctr       (upd_ctr),
        .upd_taken     (upd_taken),
        .upd_mispredict(upd_mispredict),
        .upd_ghr       (upd_ghr),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [7:0] idx, input logic [1:0] ctr, input logic taken);
        upd_valid = 1'b1; upd_index = idx; upd_ctr = ctr; upd_taken = taken; upd_mispredict = 1'b0;
        step();
        upd_valid = 1'b0;
    endtask

    // Predict so that the hashed index equals idx, given the modelled history.
    task automatic pred_check(input string tag, input logic [7:0] idx, input logic [1:0] ectr);
        pred_valid = 1'b1;
        pred_pc    = {22'd0, idx ^ tb_ghr, 2'b00};
        step();
        pred_valid = 1'b0;
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_index"}, 32'(resp_index), 32'(idx));
        chk({tag, "_ctr"},   32'(resp_ctr),   32'(ectr));
        chk({tag, "_taken"}, 32'(resp_taken), 32'(ectr[1]));
        chk({tag, "_ghr"},   32'(resp_ghr),   32'(tb_ghr));
        step();
        tb_ghr = {tb_ghr[6:0], ectr[1]};
    endtask

    task automatic sweep_check(input string tag);
        int busy_errs;
        busy_errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (init_done !== 1'b0 || pred_ready !== 1'b0) busy_errs++;
            step();
        end
        chk({tag, "_busy_cycles_bad"}, 32'(busy_errs), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        chk({tag, "_pred_ready"}, 32'(pred_ready), 32'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        tb_ghr   = 8'h00;
        rst_n = 1'b0; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_index = '0; upd_ctr = '0; upd_taken = 1'b0;
        upd_mispredict = 1'b0; upd_ghr = '0;
        #2;
        chk("rst_init_done",  32'(init_done),  32'd0);
        chk("rst_pred_ready", 32'(pred_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_ctr",   32'(resp_ctr),   32'd0);
        chk("rst_resp_index", 32'(resp_index), 32'd0);
        chk("rst_resp_ghr",   32'(resp_ghr),   32'd0);
        step();
        rst_n = 1'b1;

        // Updates during INIT (incl. mispredict repair) must be ignored.
        upd_valid = 1'b1; upd_index = 8'h40; upd_ctr = 2'b11; upd_taken = 1'b1;
        upd_mispredict = 1'b1; upd_ghr = 8'hFF;
        sweep_check("init");
        upd_valid = 1'b0; upd_mispredict = 1'b0;

        // First prediction after init: pc 0x100, ghr 0.
        pred_check("first", 8'h40, 2'b01);
        chk("first_idle_valid", 32'(resp_valid), 32'd0);

        // Saturating training.
        train(8'h40, 2'b01, 1'b1);
        pred_check("tr_01_t", 8'h40, 2'b10);
        train(8'h40, 2'b10, 1'b1);
        pred_check("tr_10_t", 8'h40, 2'b11);
        train(8'h40, 2'b11, 1'b1);
        pred_check("tr_11_t", 8'h40, 2'b11);
        train(8'h40, 2'b10, 1'b0);
        pred_check("tr_10_nt", 8'h40, 2'b01);
        train(8'h40, 2'b00, 1'b0);
        pred_check("tr_00_nt", 8'h40, 2'b00);

        // Same-cycle write and read of index 0x40: write-first.
        pred_valid = 1'b1; pred_pc = {22'd0, 8'h40 ^ tb_ghr, 2'b00};
        upd_valid = 1'b1; upd_index = 8'h40; upd_ctr = 2'b01; upd_taken = 1'b1;
        step();
        pred_valid = 1'b0;
        chk("coll_ctr",   32'(resp_ctr),   32'd2);
        chk("coll_taken", 32'(resp_taken), 32'd1);
        chk("coll_index", 32'(resp_index), 32'h40);
        // Update in the response cycle must not disturb the held response.
        upd_index = 8'h40; upd_ctr = 2'b10; upd_taken = 1'b1;
        step();
        upd_valid = 1'b0;
        chk("hold_ctr", 32'(resp_ctr), 32'd2);
        tb_ghr = {tb_ghr[6:0], 1'b1};
        pred_check("after_hold", 8'h40, 2'b11);

        // Repair history to 0 (taken=0 into checkpoint 0), writing unrelated entry 0x10.
        upd_valid = 1'b1; upd_index = 8'h10; upd_ctr = 2'b01; upd_taken = 1'b0;
        upd_mispredict = 1'b1; upd_ghr = 8'h00;
        step();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        tb_ghr = 8'h00;

        // Back-to-back: A (idx 0x40, taken) then B with forwarded history 0x01,
        // plus a mispredict repair in B's accept cycle.
        pred_valid = 1'b1; pred_pc = 32'h0000_0100;
        step();
        chk("b2b_a_ctr", 32'(resp_ctr), 32'd3);
        chk("b2b_a_ghr", 32'(resp_ghr), 32'd0);
        pred_pc = 32'h0000_0200;
        upd_valid = 1'b1; upd_index = 8'h20; upd_ctr = 2'b01; upd_taken = 1'b0;
        upd_mispredict = 1'b1; upd_ghr = 8'h5A;
        step();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        chk("b2b_b_index", 32'(resp_index), 32'h81);
        chk("b2b_b_ghr",   32'(resp_ghr),   32'h01);
        chk("b2b_b_ctr",   32'(resp_ctr),   32'd1);
        // ghr is now 0xB4; B (not taken) is in flight, so C sees 0x68.
        pred_pc = 32'h0000_0000;
        step();
        pred_valid = 1'b0;
        chk("misp_c_index", 32'(resp_index), 32'h68);
        chk("misp_c_ghr",   32'(resp_ghr),   32'h68);
        chk("misp_c_valid", 32'(resp_valid), 32'd1);

        // Reset with a response outstanding.
        rst_n = 1'b0;
        #1;
        chk("rst2_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst2_resp_ctr",   32'(resp_ctr),   32'd0);
        chk("rst2_resp_index", 32'(resp_index), 32'd0);
        chk("rst2_resp_ghr",   32'(resp_ghr),   32'd0);
        chk("rst2_init_done",  32'(init_done),  32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step();

        // Reset again mid-sweep (sweep_ptr == 100); full sweep must restart.
        rst_n = 1'b0;
        #1;
        chk("rst3_init_done",  32'(init_done),  32'd0);
        chk("rst3_pred_ready", 32'(pred_ready), 32'd0);
        rst_n = 1'b1;
        sweep_check("resweep");
        tb_ghr = 8'h00;
        pred_check("post_resweep", 8'h40, 2'b01);
        pred_check("post_resweep_81", 8'h81, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
